// File: rtl/eth_pkg.sv
// Shared Ethernet/ARP constants, FSM state encoding and the latched ARP field bundle.
// Imported by tx_arp_gen and arp_byte_rom.
package eth_pkg;

    localparam logic [15:0] ARP_HWTYPE   = 16'h0001;
    localparam logic [15:0] ARP_PROTO    = 16'h0800;
    localparam logic [7:0]  ARP_HWLEN    = 8'd6;
    localparam logic [7:0]  ARP_PROTOLEN = 8'd4;
    localparam logic [15:0] ARP_OP_REQ   = 16'd1;
    localparam logic [15:0] ARP_OP_REPLY = 16'd2;
    localparam int          ARP_BODY_LEN = 28;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PASS = 2'd1,
        S_ARP  = 2'd2
    } arp_state_t;

    // Field order matches wire order after the fixed header bytes.
    typedef struct packed {
        logic [15:0] opcode;
        logic [47:0] src_mac;
        logic [31:0] src_ip;
        logic [47:0] dst_mac;
        logic [31:0] dst_ip;
    } arp_fields_t;

endpackage

// File: rtl/arp_byte_rom.sv
// Maps a wire byte index plus latched ARP fields to one output byte and its keep bit.
// Ports: i_idx (byte index), i_fields (latched fields), o_byte (byte), o_keep (index < PAD_LEN).
module arp_byte_rom
    import eth_pkg::*;
#(
    parameter int          IW       = 6,
    parameter int          PAD_LEN  = 46,
    parameter logic [7:0]  PAD_BYTE = 8'h00
) (
    input  logic [IW-1:0] i_idx,
    input  arp_fields_t   i_fields,
    output logic [7:0]    o_byte,
    output logic          o_keep
);

    localparam logic [IW-1:0] LEN  = IW'(PAD_LEN);
    localparam logic [IW-1:0] BODY = IW'(ARP_BODY_LEN);

    logic [8*ARP_BODY_LEN-1:0] w_hdr;
    logic [8*ARP_BODY_LEN-1:0] w_shift;

    assign w_hdr = {ARP_HWTYPE, ARP_PROTO, ARP_HWLEN, ARP_PROTOLEN, i_fields};
    // Shift the wanted byte up to the top so byte 0 is the MSB of the header.
    assign w_shift = w_hdr << {i_idx[4:0], 3'b000};
    assign o_keep = (i_idx < LEN);

    always_comb begin
        o_byte = 8'h00;
        if (i_idx < BODY) begin
            o_byte = w_shift[8*ARP_BODY_LEN-1 -: 8];
        end else if (i_idx < LEN) begin
            o_byte = PAD_BYTE;
        end
    end

endmodule

// File: rtl/tx_arp_gen.sv
// ARP payload generator with a frame-boundary AXI-Stream passthrough arbiter.
// Ports: s_axis_* upstream, m_axis_* downstream, arp_* request/fields/handshake.
module tx_arp_gen
    import eth_pkg::*;
#(
    parameter int         DATA_BYTES = 1,
    parameter int         PAD_LEN    = 46,
    parameter logic [7:0] PAD_BYTE   = 8'h00
) (
    input  logic                    s_axis_aclk,
    input  logic                    s_axis_aresetn,
    input  logic                    arp_req,
    output logic                    arp_ready,
    output logic                    arp_done,
    input  logic [15:0]             arp_opcode,
    input  logic [47:0]             arp_srcMac,
    input  logic [31:0]             arp_srcIP,
    input  logic [47:0]             arp_destMac,
    input  logic [31:0]             arp_destIP,
    input  logic [8*DATA_BYTES-1:0] s_axis_tdata,
    input  logic [DATA_BYTES-1:0]   s_axis_tkeep,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tuser,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic [8*DATA_BYTES-1:0] m_axis_tdata,
    output logic [DATA_BYTES-1:0]   m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tuser,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready
);

    localparam int NBEATS = (PAD_LEN + DATA_BYTES - 1) / DATA_BYTES;
    localparam int BW     = $clog2(NBEATS + 1);
    localparam int LW     = $clog2(DATA_BYTES);
    localparam int IW     = BW + LW;
    localparam int DW     = 8 * DATA_BYTES;
    localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);

    arp_state_t       r_state;
    logic             r_pending;
    arp_fields_t      r_fields;
    logic [BW-1:0]    r_bcnt;
    logic [DW-1:0]    r_tdata;
    logic [DATA_BYTES-1:0] r_tkeep;
    logic             r_tlast;
    logic             r_tuser;
    logic             r_tvalid;

    arp_fields_t      w_fields;
    logic             w_accept;
    logic [BW-1:0]    w_ld_idx;
    logic [IW-1:0]    w_base;
    logic [DW-1:0]    w_tdata_nxt;
    logic [DATA_BYTES-1:0] w_tkeep_nxt;
    logic             w_arp_hs;

    assign w_fields  = {arp_opcode, arp_srcMac, arp_srcIP, arp_destMac, arp_destIP};
    assign arp_ready = ~r_pending;
    assign w_accept  = arp_req & ~r_pending;

    // Beat to load next: the current one on the first load, else its successor.
    assign w_ld_idx = r_tvalid ? (r_bcnt + BW'(1)) : r_bcnt;
    assign w_base   = IW'(w_ld_idx) << LW;
    assign w_arp_hs = (r_state == S_ARP) & r_tvalid & m_axis_tready;
    assign arp_done = w_arp_hs & r_tlast;

    genvar k;
    generate
        for (k = 0; k < DATA_BYTES; k++) begin : g_lane
            arp_byte_rom #(
                .IW       (IW),
                .PAD_LEN  (PAD_LEN),
                .PAD_BYTE (PAD_BYTE)
            ) u_rom (
                .i_idx    (w_base + IW'(k)),
                .i_fields (r_fields),
                .o_byte   (w_tdata_nxt[8*k +: 8]),
                .o_keep   (w_tkeep_nxt[k])
            );
        end
    endgenerate

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            r_state   <= S_IDLE;
            r_pending <= 1'b0;
            r_fields  <= '0;
            r_bcnt    <= '0;
            r_tdata   <= '0;
            r_tkeep   <= '0;
            r_tlast   <= 1'b0;
            r_tuser   <= 1'b0;
            r_tvalid  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_fields  <= w_fields;
                r_pending <= 1'b1;
            end
            unique case (r_state)
                S_IDLE: begin
                    // A request accepted this very cycle beats waiting upstream data.
                    if (r_pending | w_accept) begin
                        r_state  <= S_ARP;
                        r_bcnt   <= '0;
                        r_tvalid <= 1'b0;
                    end else if (s_axis_tvalid) begin
                        r_state <= S_PASS;
                    end
                end
                S_PASS: begin
                    if (s_axis_tvalid & m_axis_tready & s_axis_tlast) begin
                        r_state <= S_IDLE;
                    end
                end
                S_ARP: begin
                    if (!r_tvalid | m_axis_tready) begin
                        if (r_tvalid & r_tlast) begin
                            r_state   <= S_IDLE;
                            r_pending <= 1'b0;
                            r_tvalid  <= 1'b0;
                            r_tlast   <= 1'b0;
                            r_tuser   <= 1'b0;
                            r_tdata   <= '0;
                            r_tkeep   <= '0;
                        end else begin
                            if (r_tvalid) begin
                                r_bcnt <= r_bcnt + BW'(1);
                            end
                            r_tvalid <= 1'b1;
                            r_tdata  <= w_tdata_nxt;
                            r_tkeep  <= w_tkeep_nxt;
                            r_tlast  <= (w_ld_idx == LAST_BEAT);
                            r_tuser  <= (w_ld_idx == '0);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        s_axis_tready = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        m_axis_tvalid = 1'b0;
        unique case (r_state)
            S_PASS: begin
                s_axis_tready = m_axis_tready;
                m_axis_tdata  = s_axis_tdata;
                m_axis_tkeep  = s_axis_tkeep;
                m_axis_tlast  = s_axis_tlast;
                m_axis_tuser  = s_axis_tuser;
                m_axis_tvalid = s_axis_tvalid;
            end
            S_ARP: begin
                m_axis_tdata  = r_tdata;
                m_axis_tkeep  = r_tkeep;
                m_axis_tlast  = r_tlast;
                m_axis_tuser  = r_tuser;
                m_axis_tvalid = r_tvalid;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tx_arp_gen.sv
// Directed bench for tx_arp_gen: 1-byte and 4-byte instances share the ARP request inputs.
// Covers reset, ARP layout, backpressure, passthrough arbitration and mid-frame reset.
module tb_tx_arp_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        arp_req;
    logic [15:0] op;
    logic [47:0] smac, dmac;
    logic [31:0] sip, dip;

    logic [7:0]  s_tdata1;
    logic [0:0]  s_tkeep1;
    logic        s_tlast1, s_tuser1, s_tvalid1, s_tready1;
    logic [7:0]  m_tdata1;
    logic [0:0]  m_tkeep1;
    logic        m_tlast1, m_tuser1, m_tvalid1, m_tready1;
    logic        arp_ready1, arp_done1;

    logic [31:0] s_tdata4;
    logic [3:0]  s_tkeep4;
    logic        s_tlast4, s_tuser4, s_tvalid4, s_tready4;
    logic [31:0] m_tdata4;
    logic [3:0]  m_tkeep4;
    logic        m_tlast4, m_tuser4, m_tvalid4, m_tready4;
    logic        arp_ready4, arp_done4;

    tx_arp_gen dut1 (
        .s_axis_aclk(clk), .s_axis_aresetn(rst_n),
        .arp_req(arp_req), .arp_ready(arp_ready1), .arp_done(arp_done1),
        .arp_opcode(op), .arp_srcMac(smac), .arp_srcIP(sip),
        .arp_destMac(dmac), .arp_destIP(dip),
        .s_axis_tdata(s_tdata1), .s_axis_tkeep(s_tkeep1), .s_axis_tlast(s_tlast1),
        .s_axis_tuser(s_tuser1), .s_axis_tvalid(s_tvalid1), .s_axis_tready(s_tready1),
        .m_axis_tdata(m_tdata1), .m_axis_tkeep(m_tkeep1), .m_axis_tlast(m_tlast1),
        .m_axis_tuser(m_tuser1), .m_axis_tvalid(m_tvalid1), .m_axis_tready(m_tready1)
    );

    tx_arp_gen #(.DATA_BYTES(4)) dut4 (
        .s_axis_aclk(clk), .s_axis_aresetn(rst_n),
        .arp_req(arp_req), .arp_ready(arp_ready4), .arp_done(arp_done4),
        .arp_opcode(op), .arp_srcMac(smac), .arp_srcIP(sip),
        .arp_destMac(dmac), .arp_destIP(dip),
        .s_axis_tdata(s_tdata4), .s_axis_tkeep(s_tkeep4), .s_axis_tlast(s_tlast4),
        .s_axis_tuser(s_tuser4), .s_axis_tvalid(s_tvalid4), .s_axis_tready(s_tready4),
        .m_axis_tdata(m_tdata4), .m_axis_tkeep(m_tkeep4), .m_axis_tlast(m_tlast4),
        .m_axis_tuser(m_tuser4), .m_axis_tvalid(m_tvalid4), .m_axis_tready(m_tready4)
    );

    logic [7:0] EXP [46] = '{
        8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01,
        8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
        8'hC0, 8'hA8, 8'h01, 8'h0A,
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
        8'hC0, 8'hA8, 8'h01, 8'h01,
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    int n_checks = 0;
    int n_err    = 0;
    int done1    = 0;
    int done4    = 0;
    int n_stall  = 0;

    logic [9:0]  q1 [$];
    logic [37:0] q4 [$];
    logic        stall_prev = 1'b0;
    logic [9:0]  prev_beat  = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Samples at the falling edge: inputs change 2 time units after the rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && m_tvalid1) begin
                n_stall++;
                chk("stall_hold", {m_tuser1, m_tlast1, m_tdata1}, prev_beat);
            end
            if (m_tvalid1 && m_tready1) q1.push_back({m_tuser1, m_tlast1, m_tdata1});
            if (arp_done1) done1++;
            stall_prev = m_tvalid1 & ~m_tready1;
            prev_beat  = {m_tuser1, m_tlast1, m_tdata1};
            if (m_tvalid4 && m_tready4) q4.push_back({m_tuser4, m_tlast4, m_tkeep4, m_tdata4});
            if (arp_done4) done4++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_req();
        arp_req = 1'b1;
        tick();
        arp_req = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int c = 0; c < 600 && done1 < target; c++) tick();
        chk("done_wait", done1 >= target, 1);
    endtask

    task automatic cmp_arp(input int base);
        chk("arp_len", q1.size() >= base + 46, 1);
        if (q1.size() >= base + 46) begin
            for (int i = 0; i < 46; i++) begin
                chk($sformatf("arp_byte%0d", i), q1[base+i][7:0], EXP[i]);
                chk($sformatf("arp_flag%0d", i), q1[base+i][9:8], {i == 0, i == 45});
            end
        end
    endtask

    task automatic cmp_pass(input int base, input int len, input logic [7:0] b0);
        chk("pass_len", q1.size() >= base + len, 1);
        if (q1.size() >= base + len) begin
            for (int i = 0; i < len; i++) begin
                chk($sformatf("pass_beat%0d", i), q1[base+i],
                    {i == 0, i == len - 1, b0 + 8'(i)});
            end
        end
    endtask

    task automatic drive_frame(input int len, input logic [7:0] b0, input int req_at);
        int   b;
        int   cyc;
        logic hs;
        logic sent;
        b = 0; cyc = 0; sent = 1'b0;
        while (b < len && cyc < 600) begin
            s_tvalid1 = 1'b1;
            s_tdata1  = b0 + 8'(b);
            s_tuser1  = (b == 0);
            s_tlast1  = (b == len - 1);
            s_tkeep1  = 1'b1;
            arp_req   = (b == req_at) && !sent;
            if (arp_req) sent = 1'b1;
            @(negedge clk);
            hs = s_tready1;
            tick();
            cyc++;
            if (hs) b++;
        end
        s_tvalid1 = 1'b0; s_tlast1 = 1'b0; s_tuser1 = 1'b0; arp_req = 1'b0;
        chk("frame_done", b, len);
    endtask

    initial begin
        int d0;
        rst_n = 1'b0; arp_req = 1'b0;
        op = 16'd1; smac = 48'h02_00_00_00_00_01; sip = 32'hC0A8_010A;
        dmac = 48'h0; dip = 32'hC0A8_0101;
        s_tdata1 = '0; s_tkeep1 = '0; s_tlast1 = 0; s_tuser1 = 0; s_tvalid1 = 0;
        s_tdata4 = '0; s_tkeep4 = '0; s_tlast4 = 0; s_tuser4 = 0; s_tvalid4 = 0;
        m_tready1 = 1'b1; m_tready4 = 1'b1;

        repeat (2) @(posedge clk);
        #2;
        chk("rst_out1", {m_tvalid1, m_tlast1, m_tuser1, m_tkeep1, m_tdata1, s_tready1, arp_done1}, 0);
        chk("rst_out4", {m_tvalid4, m_tlast4, m_tuser4, m_tkeep4, m_tdata4, s_tready4, arp_done4}, 0);
        chk("rst_ready", {arp_ready1, arp_ready4}, 2'b11);
        rst_n = 1'b1;
        tick();

        // Tests 1 and 2: plain ARP frame on both widths.
        pulse_req();
        chk("ready_low", arp_ready1, 0);
        wait_done(1);
        tick();
        chk("ready_back", arp_ready1, 1);
        cmp_arp(0);
        chk("done_once", done1, 1);
        chk("w4_beats", q4.size(), 12);
        chk("w4_done", done4, 1);
        if (q4.size() == 12) begin
            chk("w4_beat0", q4[0][31:0], 32'h0008_0100);
            for (int i = 0; i < 12; i++) begin
                chk($sformatf("w4_keep%0d", i), q4[i][35:32], (i == 11) ? 4'b0011 : 4'b1111);
                chk($sformatf("w4_flag%0d", i), q4[i][37:36], {i == 0, i == 11});
                for (int k = 0; k < 4; k++) begin
                    chk($sformatf("w4_b%0d_%0d", i, k), q4[i][8*k +: 8],
                        (4*i + k < 46) ? EXP[4*i+k] : 8'h00);
                end
            end
        end

        // Test 3: tready toggling every cycle.
        q1.delete();
        d0 = done1;
        pulse_req();
        for (int c = 0; c < 600 && done1 < d0 + 1; c++) begin
            m_tready1 = c[0];
            tick();
        end
        m_tready1 = 1'b1;
        chk("bp_done", done1, d0 + 1);
        chk("bp_stalls_seen", n_stall > 0, 1);
        cmp_arp(0);

        // Test 4: request mid-passthrough, then an ignored request during ARP.
        repeat (20) tick();
        q1.delete();
        d0 = done1;
        drive_frame(60, 8'h40, 10);
        for (int c = 0; c < 200 && q1.size() < 65; c++) tick();
        chk("arp_started", q1.size() >= 65, 1);
        chk("busy_ready", arp_ready1, 0);
        pulse_req();
        wait_done(d0 + 1);
        repeat (80) tick();
        chk("one_done", done1, d0 + 1);
        chk("t4_total", q1.size(), 106);
        cmp_pass(0, 60, 8'h40);
        cmp_arp(60);

        // Test 5: same-cycle request and upstream valid; ARP goes first.
        q1.delete();
        d0 = done1;
        drive_frame(8, 8'hA0, 0);
        repeat (5) tick();
        chk("t5_done", done1, d0 + 1);
        chk("t5_total", q1.size(), 54);
        cmp_arp(0);
        cmp_pass(46, 8, 8'hA0);

        // Test 6: reset at ARP beat 20.
        repeat (20) tick();
        q1.delete();
        pulse_req();
        for (int c = 0; c < 200 && q1.size() < 20; c++) tick();
        chk("t6_beats", q1.size(), 20);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out", {m_tvalid1, m_tlast1, m_tuser1, m_tkeep1, m_tdata1, s_tready1, arp_done1}, 0);
        chk("mid_rst_ready", arp_ready1, 1);
        chk("no_early_last", (q1.size() > 19) ? q1[19][8] : 1'b1, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", arp_ready1, 1);
        q1.delete();
        d0 = done1;
        pulse_req();
        wait_done(d0 + 1);
        tick();
        cmp_arp(0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
